// File: rtl/wbu_commit.sv
// Write-back/commit stage: owns the architectural GPR and machine-mode CSR files,
// the 64-bit cycle/instret counters, and halts the core on an ebreak commit.
module wbu_commit #(
    parameter int unsigned NR_GPR    = 32,
    parameter logic [31:0] VENDOR_ID = 32'h79737978,
    parameter logic [31:0] ARCH_ID   = 32'h015FDEEB
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_gpr_waddr,
    input  logic [31:0] in_gpr_wdata,
    input  logic        in_csr_wen,
    input  logic [11:0] in_csr_waddr,
    input  logic [31:0] in_csr_wdata,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic [11:0] csr_raddr,
    output logic [31:0] csr_rdata,
    output logic        retire,
    output logic        halted,
    output logic [31:0] halt_code
);

    localparam int unsigned AW = $clog2(NR_GPR);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;

    typedef enum logic {RUN, HALT} state_t;

    state_t      state;
    logic [31:0] gpr [NR_GPR];
    logic        mie;
    logic        mpie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic fire;
    logic ebreak;
    logic gpr_we;
    logic csr_we;
    logic wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi;

    assign in_ready = (state == RUN);
    assign halted   = (state == HALT);
    assign fire     = in_valid & in_ready;
    assign ebreak   = fire & in_csr_wen & (in_csr_waddr == 12'h000);
    assign gpr_we   = fire & (in_gpr_waddr != 5'd0) & (32'(in_gpr_waddr) < NR_GPR);
    assign csr_we   = fire & in_csr_wen & (in_csr_waddr != 12'h000);

    assign wr_cyc_lo = csr_we & (in_csr_waddr == A_MCYCLE);
    assign wr_cyc_hi = csr_we & (in_csr_waddr == A_MCYCLEH);
    assign wr_ins_lo = csr_we & (in_csr_waddr == A_MINSTRET);
    assign wr_ins_hi = csr_we & (in_csr_waddr == A_MINSTRETH);

    // GPR read with write-through of the instruction committing this cycle
    function automatic logic [31:0] gpr_read(input logic [4:0] a);
        if (a == 5'd0 || 32'(a) >= NR_GPR) return 32'd0;
        if (gpr_we && a == in_gpr_waddr) return in_gpr_wdata;
        return gpr[a[AW-1:0]];
    endfunction

    function automatic logic csr_writable(input logic [11:0] a);
        return (a == A_MSTATUS) || (a == A_MTVEC) || (a == A_MEPC) || (a == A_MCAUSE) ||
               (a == A_MCYCLE) || (a == A_MCYCLEH) || (a == A_MINSTRET) || (a == A_MINSTRETH);
    endfunction

    // Value a write of d to address a leaves behind, after field masking
    function automatic logic [31:0] csr_wval(input logic [11:0] a, input logic [31:0] d);
        case (a)
            A_MSTATUS: return {19'd0, 2'b11, 3'd0, d[7], 3'd0, d[3], 3'd0};
            A_MTVEC:   return {d[31:2], 2'b00};
            A_MEPC:    return {d[31:1], 1'b0};
            default:   return d;
        endcase
    endfunction

    function automatic logic [31:0] csr_stored(input logic [11:0] a);
        case (a)
            A_MSTATUS:   return {19'd0, 2'b11, 3'd0, mpie, 3'd0, mie, 3'd0};
            A_MTVEC:     return mtvec;
            A_MEPC:      return mepc;
            A_MCAUSE:    return mcause;
            A_MCYCLE:    return mcycle[31:0];
            A_MCYCLEH:   return mcycle[63:32];
            A_MINSTRET:  return minstret[31:0];
            A_MINSTRETH: return minstret[63:32];
            A_MVENDORID: return VENDOR_ID;
            A_MARCHID:   return ARCH_ID;
            default:     return 32'd0;
        endcase
    endfunction

    always_comb begin
        rs1_data = gpr_read(rs1_addr);
        rs2_data = gpr_read(rs2_addr);
        csr_rdata = csr_stored(csr_raddr);
        if (csr_we && csr_raddr == in_csr_waddr && csr_writable(csr_raddr))
            csr_rdata = csr_wval(csr_raddr, in_csr_wdata);
    end

    // Run/halt state, retire pulse and halt code capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            retire    <= 1'b0;
            halt_code <= 32'd0;
        end else begin
            retire <= fire;
            case (state)
                RUN: if (ebreak) begin
                    state     <= HALT;
                    halt_code <= gpr_read(5'd10);
                end
                HALT: state <= HALT;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NR_GPR; i++) gpr[i] <= 32'd0;
        end else if (gpr_we) begin
            gpr[in_gpr_waddr[AW-1:0]] <= in_gpr_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mie    <= 1'b0;
            mpie   <= 1'b0;
            mtvec  <= 32'd0;
            mepc   <= 32'd0;
            mcause <= 32'd0;
        end else if (csr_we) begin
            case (in_csr_waddr)
                A_MSTATUS: begin
                    mie  <= in_csr_wdata[3];
                    mpie <= in_csr_wdata[7];
                end
                A_MTVEC:  mtvec  <= csr_wval(A_MTVEC, in_csr_wdata);
                A_MEPC:   mepc   <= csr_wval(A_MEPC, in_csr_wdata);
                A_MCAUSE: mcause <= in_csr_wdata;
                default: ;
            endcase
        end
    end

    // A software write to either counter half suppresses that counter's increment
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcycle   <= 64'd0;
            minstret <= 64'd0;
        end else begin
            if (wr_cyc_lo)          mcycle[31:0]  <= in_csr_wdata;
            else if (wr_cyc_hi)     mcycle[63:32] <= in_csr_wdata;
            else if (state == RUN)  mcycle        <= mcycle + 64'd1;

            if (wr_ins_lo)              minstret[31:0]  <= in_csr_wdata;
            else if (wr_ins_hi)         minstret[63:32] <= in_csr_wdata;
            else if (fire && !ebreak)   minstret        <= minstret + 64'd1;
        end
    end

endmodule
